// File: rtl/mem_pkg.sv
// Shared constants, state encoding and pointer arithmetic for the memory copy/fill engine.
package mem_pkg;

    localparam int MEM_AW    = 16;
    localparam int MEM_DW    = 16;
    localparam int MEM_DEPTH = 64;
    localparam int MEM_LW    = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
        return (p + 1 >= depth) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/mem_addr_ptr.sv
// Loadable word pointer that wraps from DEPTH-1 back to 0; load has priority over inc.
module mem_addr_ptr
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int PW    = $clog2(MEM_DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    input  logic          inc,
    output logic [PW-1:0] value
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= PW'(wrap_inc(32'(value), DEPTH));
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / block fill initiator for the shared data-memory port.
// States: IDLE wait for start | READ fetch source word | WRITE store word | DONE one-cycle completion.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    parameter int DEPTH = MEM_DEPTH,
    parameter int LW    = MEM_LW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic          fill,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [LW-1:0] count,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    state_t        state;
    logic          fill_q;
    logic [DW-1:0] fill_val_q;
    logic [LW-1:0] len_q;
    logic [DW-1:0] rd_buf;
    logic [DW-1:0] wd_hold;
    logic [LW-1:0] count_q;
    logic          aborted_q;

    logic          accept;
    logic [LW-1:0] len_sat;
    logic [LW-1:0] count_nx;
    logic [DW-1:0] wd_cur;
    logic [PW-1:0] src_ptr;
    logic [PW-1:0] dst_ptr;
    logic [PW-1:0] src_load_val;
    logic [PW-1:0] dst_load_val;

    assign accept       = (state == ST_IDLE) && start;
    assign len_sat      = (len > DEPTH_L) ? DEPTH_L : len;
    assign count_nx     = count_q + LW'(1);
    assign wd_cur       = fill_q ? fill_val_q : rd_buf;
    assign src_load_val = PW'(src_addr % DEPTH_A);
    assign dst_load_val = PW'(dst_addr % DEPTH_A);

    mem_addr_ptr #(.DEPTH(DEPTH), .PW(PW)) u_src_ptr (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (accept),
        .load_val (src_load_val),
        .inc      ((state == ST_READ) && !abort),
        .value    (src_ptr)
    );

    mem_addr_ptr #(.DEPTH(DEPTH), .PW(PW)) u_dst_ptr (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (accept),
        .load_val (dst_load_val),
        .inc      (state == ST_WRITE),
        .value    (dst_ptr)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            fill_q     <= 1'b0;
            fill_val_q <= '0;
            len_q      <= '0;
            rd_buf     <= '0;
            wd_hold    <= '0;
            count_q    <= '0;
            aborted_q  <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fill_q     <= fill;
                        fill_val_q <= fill_val;
                        len_q      <= len_sat;
                        count_q    <= '0;
                        if (len_sat == '0)
                            state <= ST_DONE;
                        else
                            state <= fill ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    // an aborted read is simply dropped; nothing was committed
                    if (abort) begin
                        state     <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        rd_buf <= mem_RD;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // the falling-edge write already happened, so it is always counted
                    count_q <= count_nx;
                    wd_hold <= wd_cur;
                    if (abort) begin
                        state     <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else if (count_nx == len_q) begin
                        state <= ST_DONE;
                    end else begin
                        state <= fill_q ? ST_WRITE : ST_READ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign aborted = aborted_q;
    assign count   = count_q;
    assign mem_WE  = (state == ST_WRITE);
    assign mem_A   = AW'((state == ST_READ) ? src_ptr : dst_ptr);
    assign mem_WD  = (state == ST_WRITE) ? wd_cur : wd_hold;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 64-word memory on the data port.
module tb_mem_copy_engine;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start, fill, abort;
    logic [15:0] src_addr, dst_addr, fill_val;
    logic [6:0]  len;
    logic        busy, done, aborted, mem_WE;
    logic [6:0]  count;
    logic [15:0] mem_A, mem_WD, mem_RD;

    logic [15:0] mem [64];
    logic [15:0] shadow [64];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mem_copy_engine dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .fill(fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted), .count(count),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    assign mem_RD = mem[mem_A[5:0]];

    always @(negedge CLK) begin
        if (mem_WE === 1'b1) mem[mem_A[5:0]] = mem_WD;
    end

    typedef struct {
        logic        fill;
        int          src;
        int          dst;
        int          len;
        logic [15:0] fv;
        logic        abort_start;
        int          exp_done;
        int          exp_cnt;
        int          exp_wr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 16'(i);
            shadow[i] = 16'(i);
        end
    endtask

    task automatic model(input vec_t v);
        int n;
        n = (v.len > 64) ? 64 : v.len;
        for (int i = 0; i < n; i++)
            shadow[(v.dst + i) % 64] = v.fill ? v.fv : shadow[(v.src + i) % 64];
    endtask

    task automatic run_vec(input vec_t v, output int done_c, output int wr_c,
                           output int busy_c, output int max_a, output int abt_c);
        done_c = -1; wr_c = 0; busy_c = 0; max_a = 0; abt_c = 0;
        @(negedge CLK);
        fill = v.fill; src_addr = 16'(v.src); dst_addr = 16'(v.dst);
        len = 7'(v.len); fill_val = v.fv; abort = v.abort_start; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 300 && done_c < 0; c++) begin
            if (busy)    busy_c++;
            if (mem_WE)  wr_c++;
            if (aborted) abt_c++;
            if (int'(mem_A) > max_a) max_a = int'(mem_A);
            if (done)    done_c = c;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int dc, wc, bc, ma, ac, bad, ex_ab, ex_dn, ex_we;

        vecs[0] = '{1'b0,  4, 32,  4, 16'h0000, 1'b0,  9,  4,  4};
        vecs[1] = '{1'b1,  0, 10,  3, 16'hBEEF, 1'b0,  4,  3,  3};
        vecs[2] = '{1'b0, 62,  0,  4, 16'h0000, 1'b0,  9,  4,  4};
        vecs[3] = '{1'b0,  1,  2,  0, 16'h0000, 1'b0,  1,  0,  0};
        vecs[4] = '{1'b1,  0,  5, 80, 16'h0A5A, 1'b0, 65, 64, 64};
        vecs[5] = '{1'b0,  8, 10,  4, 16'h0000, 1'b0,  9,  4,  4};
        vecs[6] = '{1'b0,  0, 48,  2, 16'h0000, 1'b1,  5,  2,  2};

        RST_N = 1'b0; start = 0; fill = 0; abort = 0;
        src_addr = 0; dst_addr = 0; len = 0; fill_val = 0;
        preload();
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(mem_WE), 0);
        chk("rst_outs", int'(count) + int'(mem_A) + int'(mem_WD) + int'(aborted), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        for (int k = 0; k < 7; k++) begin
            preload();
            model(vecs[k]);
            run_vec(vecs[k], dc, wc, bc, ma, ac);
            chk($sformatf("v%0d_done_cycle", k), dc, vecs[k].exp_done);
            chk($sformatf("v%0d_writes", k), wc, vecs[k].exp_wr);
            chk($sformatf("v%0d_busy_cycles", k), bc, vecs[k].exp_done);
            chk($sformatf("v%0d_count", k), int'(count), vecs[k].exp_cnt);
            chk($sformatf("v%0d_idle_after", k), int'(busy), 0);
            chk($sformatf("v%0d_aborted", k), ac, 0);
            chk($sformatf("v%0d_max_addr_ok", k), int'(ma <= 63), 1);
            bad = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== shadow[i]) bad++;
            chk($sformatf("v%0d_mem_mismatches", k), bad, 0);
        end

        // copy result spot-checks and wrap ordering from hand-derived values
        preload();
        run_vec(vecs[0], dc, wc, bc, ma, ac);
        chk("copy_mem32", int'(mem[32]), 4);
        chk("copy_mem35", int'(mem[35]), 7);
        chk("copy_src_kept", int'(mem[7]), 7);
        preload();
        run_vec(vecs[2], dc, wc, bc, ma, ac);
        chk("wrap_mem0", int'(mem[0]), 62);
        chk("wrap_mem1", int'(mem[1]), 63);
        chk("wrap_mem2", int'(mem[2]), 62);
        chk("wrap_mem3", int'(mem[3]), 63);

        // abort during the third fill write, with an ignored start while busy
        preload();
        @(negedge CLK);
        fill = 1; src_addr = 0; dst_addr = 20; len = 8; fill_val = 16'h1234; start = 1;
        @(posedge CLK); #1;
        start = 0;
        chk("abt_c1_we", int'(mem_WE), 1);
        @(posedge CLK); #1;
        fill = 0; dst_addr = 40; len = 2; start = 1;
        @(posedge CLK); #1;
        start = 0;
        chk("abt_c3_we", int'(mem_WE), 1);
        abort = 1;
        @(posedge CLK); #1;
        abort = 0;
        chk("abt_pulse", int'(aborted), 1);
        chk("abt_busy", int'(busy), 0);
        chk("abt_count", int'(count), 3);
        ex_ab = 0; ex_dn = 0; ex_we = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            if (aborted) ex_ab++;
            if (done)    ex_dn++;
            if (mem_WE)  ex_we++;
        end
        chk("abt_single_pulse", ex_ab, 0);
        chk("abt_no_done", ex_dn, 0);
        chk("abt_no_more_writes", ex_we, 0);
        chk("abt_mem20", int'(mem[20]), 16'h1234);
        chk("abt_mem22", int'(mem[22]), 16'h1234);
        chk("abt_mem23", int'(mem[23]), 23);
        chk("abt_mem40", int'(mem[40]), 40);

        // reset asserted between edges in the second WRITE of a copy
        preload();
        @(negedge CLK);
        fill = 0; src_addr = 8; dst_addr = 50; len = 4; start = 1;
        @(posedge CLK); #1;
        start = 0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("rstm_we_before", int'(mem_WE), 1);
        #1 RST_N = 1'b0;
        #1;
        chk("rstm_we", int'(mem_WE), 0);
        chk("rstm_busy", int'(busy), 0);
        chk("rstm_done", int'(done), 0);
        chk("rstm_count", int'(count), 0);
        chk("rstm_addr", int'(mem_A), 0);
        chk("rstm_wd", int'(mem_WD), 0);
        @(negedge CLK); #1;
        chk("rstm_mem50", int'(mem[50]), 8);
        chk("rstm_mem51", int'(mem[51]), 51);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("rstm_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator for the data memory port: sequences A, WD and WE, and samples RD.
- Executes block copy (memory to memory) or block fill (constant to memory) over a word range, without CPU involvement.
- Sits beside the pipeline MEM stage on a muxed data-memory port. The arbiter grants the port to this block while busy=1.

Parameters:
- AW, 16: address/data-memory address width.
- DW, 16: data word width.
- DEPTH, 64: number of memory words; addresses wrap modulo DEPTH.
- LW, 7: width of the length and count fields (covers 0..DEPTH).

Ports:
- CLK  input  1  system clock, rising-edge logic.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- fill  input  1  1 = fill with fill_val, 0 = copy; sampled with start.
- src_addr  input  AW  copy source base.
- dst_addr  input  AW  destination base.
- len  input  LW  number of words to transfer.
- fill_val  input  DW  fill constant.
- abort  input  1  terminate the operation.
- busy  output  1  high from the cycle after start until DONE is left.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  one-cycle pulse on abort termination.
- count  output  LW  words written so far; held after completion.
- mem_A  output  AW  memory address.
- mem_WD  output  DW  memory write data.
- mem_WE  output  1  memory write enable; memory writes on the CLK falling edge.
- mem_RD  input  DW  memory read data, combinational from mem_A.

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE; busy, done, aborted, mem_WE = 0; mem_A, mem_WD, count = 0; internal pointers and buffer = 0.
- Reset mid-operation: abandons the transfer immediately. mem_WE drops asynchronously, so no further write occurs.
- State IDLE:
  - Outputs: mem_WE=0, busy=0.
  - On start=1: latch src, dst, len, fill, fill_val; clear count.
  - If len=0: go to DONE. No memory access occurs.
  - Otherwise: go to WRITE if fill=1, else READ.
- State READ (copy only):
  - Drive mem_A=src_ptr, mem_WE=0.
  - At the rising edge: buf <= mem_RD, src_ptr <= (src_ptr+1) mod DEPTH, go to WRITE.
- State WRITE:
  - Drive mem_A=dst_ptr, mem_WE=1, mem_WD = fill ? fill_val : buf.
  - The memory commits the word on the falling edge of this cycle.
  - At the rising edge: dst_ptr <= (dst_ptr+1) mod DEPTH, count <= count+1.
  - If count+1 == len: go to DONE. Otherwise go to READ (copy) or WRITE (fill).
- State DONE: done=1 for exactly one cycle, busy=1, mem_WE=0. Next state IDLE.
- Latency, N>0 words:
  - Copy: 2N busy cycles in READ/WRITE, then 1 DONE cycle.
  - Fill: N cycles in WRITE, then 1 DONE cycle.
  - start at edge k gives the first memory access in cycle k+1.
- Abort:
  - Sampled at every rising edge in READ or WRITE.
  - If asserted, the state goes to IDLE and aborted pulses for 1 cycle; done does not pulse.
  - A WRITE cycle during which abort is high still completes its falling-edge write and its count increment. A READ cycle is discarded.
  - abort in IDLE or DONE is ignored.
- start while busy: ignored; the inputs are not re-latched.
- Simultaneous start and abort in IDLE: start wins.
- Address wrap: pointers wrap from DEPTH-1 to 0. Upper AW bits of mem_A are zero above log2(DEPTH).
- Overlap: copy is strictly ascending. When dst is in (src, src+len), the source is overwritten before it is read, and the result is defined by that ordering.
- len > DEPTH: saturates to DEPTH.
- mem_WD holds its last value when mem_WE=0.

Decomposition:
- Shared package mem_pkg:
  - AW, DW, DEPTH constants.
  - State enum {IDLE, READ, WRITE, DONE}.
  - Wrap-increment function.
- One sub-module, mem_addr_ptr: a loadable wrap-around pointer (load, inc, value). Instantiated twice, for src and dst.
- FSM and datapath live in mem_copy_engine.

Test Plan:
- Copy, memory preloaded mem[i]=i:
  - Stimulus: src=4, dst=32, len=4.
  - Required: mem[32..35]=4,5,6,7; done pulses exactly 9 cycles after the start edge; count=4; mem[4..7] unchanged.
- Fill:
  - Stimulus: fill=1, fill_val=16'hBEEF, dst=10, len=3.
  - Required: mem[10..12]=BEEF; no READ cycles (mem_WE=1 for 3 consecutive cycles); done on the 4th cycle.
- Wrap:
  - Stimulus: copy src=62, dst=0, len=4.
  - Required: mem[0..3] = the old mem[62], mem[63], mem[0], mem[1] in read order (forward-overlap rule).
  - Required: mem_A never exceeds 63.
- len=0:
  - Required: no cycle with mem_WE=1; busy high 1 cycle; done pulses the cycle after start; count=0.
- Abort:
  - Stimulus: fill len=8; abort during the 3rd WRITE cycle.
  - Required: exactly 3 words written; count=3; aborted pulses once; done stays 0; start ignored while busy.
- Reset mid-copy:
  - Stimulus: RST_N low between edges during WRITE.
  - Required: mem_WE drops immediately; that word is not written; all outputs return to 0.
